aes_round_engine: RTL and testbench



---
 rtl/aes_round_engine.sv | 177 +++++++++++++++++
 tb/tb_aes_round_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption datapath, one state column per cycle.
// Pulls round keys word by word from the upstream key expander.
module s_box (
    input  logic [31:0] a,
    output logic [31:0] y
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] lut(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    assign y = {lut(a[31:24]), lut(a[23:16]),
                lut(a[15:8]),  lut(a[7:0])};
endmodule

module aes_round_engine #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic        key_ready,
    output logic [3:0]  round_key_num,
    output logic [1:0]  r_index,
    input  logic [31:0] round_key,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        OUTPUT
    } fsm_t;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    fsm_t         st, st_nx;
    logic [1:0]   col;
    logic [3:0]   rnd;
    logic [127:0] state_q;
    logic [127:0] buf_q;
    logic [31:0]  cur_col;
    logic [31:0]  sw0, sw1, sw2, sw3;
    logic [31:0]  shifted, subbed, new_col;
    logic         last_col, last_rnd;

    function automatic logic [31:0] word_at(
        input logic [127:0] s,
        input logic [1:0]   c
    );
        return s[{~c, 5'd0} +: 32];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    assign last_col = (col == 2'd3);
    assign last_rnd = (rnd == LAST_RND);
    assign cur_col  = word_at(state_q, col);

    // ShiftRows: row r of this column comes from column col+r
    assign sw0 = word_at(state_q, col);
    assign sw1 = word_at(state_q, col + 2'd1);
    assign sw2 = word_at(state_q, col + 2'd2);
    assign sw3 = word_at(state_q, col + 2'd3);
    assign shifted = {sw0[31:24], sw1[23:16],
                      sw2[15:8],  sw3[7:0]};

    s_box u_sbox (
        .a (shifted),
        .y (subbed)
    );

    always_comb begin
        new_col = cur_col ^ round_key;
        unique case (1'b1)
            (rnd == 4'd0): new_col = cur_col ^ round_key;
            last_rnd:      new_col = subbed ^ round_key;
            default:       new_col = mix(subbed) ^ round_key;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= IDLE;
        else       st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        unique case (st)
            IDLE:    if (start) st_nx = LOAD;
            LOAD:    if (last_col) st_nx = ROUND;
            ROUND: begin
                if (key_ready && last_col && last_rnd)
                    st_nx = OUTPUT;
            end
            OUTPUT:  if (last_col) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col     <= 2'd0;
            rnd     <= 4'd0;
            state_q <= '0;
            buf_q   <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (start) begin
                        col <= 2'd0;
                        rnd <= 4'd0;
                    end
                end
                LOAD: begin
                    state_q[{~col, 5'd0} +: 32] <= data_in;
                    col <= col + 2'd1;
                end
                ROUND: begin
                    if (key_ready) begin
                        buf_q[{~col, 5'd0} +: 32] <= new_col;
                        col <= col + 2'd1;
                        // whole round commits at once so earlier
                        // columns never feed later ones
                        if (last_col) begin
                            state_q <= {buf_q[127:32], new_col};
                            if (!last_rnd) rnd <= rnd + 4'd1;
                        end
                    end
                end
                OUTPUT:  col <= col + 2'd1;
                default: col <= 2'd0;
            endcase
        end
    end

    assign busy          = (st != IDLE);
    assign data_valid    = (st == OUTPUT);
    assign data_out      = data_valid ? cur_col : 32'd0;
    assign round_key_num = (st == ROUND) ? rnd : 4'd0;
    assign r_index       = (st == ROUND) ? ~col : 2'd0;
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed and randomized bench for aes_round_engine against
// a byte-level AES-128 reference with its own key schedule.
module tb_aes_round_engine;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic        key_ready;
    logic [3:0]  round_key_num;
    logic [1:0]  r_index;
    logic [31:0] round_key;
    logic [31:0] data_out;
    logic        data_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc;

    logic [7:0]  sbox_t [256];
    logic [31:0] rk [44];

    aes_round_engine #(.NUM_ROUNDS(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .data_in       (data_in),
        .key_ready     (key_ready),
        .round_key_num (round_key_num),
        .r_index       (r_index),
        .round_key     (round_key),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expander model: r_index k selects bits [32k +: 32], i.e. w[3-k]
    always_comb begin
        round_key = 32'd0;
        if (round_key_num <= 4'd10)
            round_key = rk[4 * int'(round_key_num) + 3 - int'(r_index)];
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (round_key_num <= 4'd10) else begin
                errors++;
                $error("FAIL key_num_range observed=%0d expected<=10",
                       round_key_num);
            end
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'd0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b,
                                        input int k);
        return 8'((b << k) | (b >> (8 - k)));
    endfunction

    // S-box from first principles: GF(2^8) inverse then affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'd0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'd1) inv = 8'(y);
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
                      ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]],
                sbox_t[w[15:8]],  sbox_t[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) rk[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = rk[i - 1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'd0};
                rc = gmul(rc, 8'h02);
            end
            rk[i] = rk[i - 4] ^ t;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  mc [4];
        logic [7:0]  acc;
        logic [31:0] w;
        logic [127:0] ct;
        mc[0] = 8'h02; mc[1] = 8'h03; mc[2] = 8'h01; mc[3] = 8'h01;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int q = 0; q < 4; q++)
                        s[4 * c + q] = t[4 * ((c + q) % 4) + q];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int q = 0; q < 4; q++) t[q] = s[4 * c + q];
                        for (int q = 0; q < 4; q++) begin
                            acc = 8'd0;
                            for (int j = 0; j < 4; j++)
                                acc = acc ^ gmul(mc[(j - q + 4) % 4], t[j]);
                            s[4 * c + q] = acc;
                        end
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                w = rk[4 * r + c];
                for (int q = 0; q < 4; q++)
                    s[4 * c + q] = s[4 * c + q] ^ w[31 - 8 * q -: 8];
            end
        end
        for (int i = 0; i < 16; i++) ct[127 - 8 * i -: 8] = s[i];
        return ct;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_abort();
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(data_valid), 32'd0);
        check("abort_dout", data_out, 32'd0);
        check("abort_keynum", 32'(round_key_num), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        key_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One block from the start cycle T; bench is at posedge+1 of T.
    task automatic run_block(input logic [127:0] pt,
                             input logic [127:0] ct,
                             input int st_r,
                             input int st_c,
                             input int st_n,
                             input int repulse,
                             input int abort_at,
                             input bit start_at_end);
        cyc = 0;
        start = 1'b1;
        key_ready = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(data_valid), 32'd0);
        next_cyc();
        start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            data_in = pt[127 - 32 * n -: 32];
            @(negedge clk);
            check("load_busy", 32'(busy), 32'd1);
            next_cyc();
        end
        data_in = $urandom;
        for (int r = 0; r <= 10; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r == st_r && c == st_c) begin
                    repeat (st_n) begin
                        key_ready = 1'b0;
                        @(negedge clk);
                        check("stall_knum", 32'(round_key_num), 32'(r));
                        check("stall_ridx", 32'(r_index), 32'(3 - c));
                        next_cyc();
                    end
                    key_ready = 1'b1;
                end
                if (cyc == repulse) begin
                    start = 1'b1;
                    data_in = $urandom;
                end
                if (cyc == abort_at) begin
                    do_abort();
                    return;
                end
                @(negedge clk);
                check("knum", 32'(round_key_num), 32'(r));
                check("ridx", 32'(r_index), 32'(3 - c));
                check("rnd_valid", 32'(data_valid), 32'd0);
                next_cyc();
                start = 1'b0;
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (cyc == abort_at) begin
                do_abort();
                return;
            end
            if (start_at_end && c == 3) start = 1'b1;
            @(negedge clk);
            check("out_valid", 32'(data_valid), 32'd1);
            check("out_busy", 32'(busy), 32'd1);
            check("out_word", data_out, ct[127 - 32 * c -: 32]);
            next_cyc();
            start = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    logic [127:0] key_b, pt_b, ct_b, key_c, pt_c, ct_c;
    logic [127:0] key, pt;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        key_ready = 1'b1;
        data_in = 32'd0;
        key_b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
        ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
        key_c = 128'h000102030405060708090a0b0c0d0e0f;
        pt_c  = 128'h00112233445566778899aabbccddeeff;
        ct_c  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        build_sbox();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_dout", data_out, 32'd0);
        check("rst_knum", 32'(round_key_num), 32'd0);
        check("rst_ridx", 32'(r_index), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        expand(key_b);
        run_block(pt_b, ct_b, -1, -1, 0, -1, -1, 1'b0);
        expand(key_c);
        run_block(pt_c, ct_c, -1, -1, 0, -1, -1, 1'b0);
        expand(key_b);
        run_block(pt_b, ct_b, 4, 2, 7, -1, -1, 1'b0);

        run_block(pt_b, ct_b, -1, -1, 0, 20, -1, 1'b1);
        pt = {$urandom, $urandom, $urandom, $urandom};
        run_block(pt, aes_enc(pt), -1, -1, 0, -1, -1, 1'b0);

        run_block(pt_b, ct_b, -1, -1, 0, -1, 30, 1'b0);
        key = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
        expand(key);
        run_block(pt, aes_enc(pt), -1, -1, 0, -1, -1, 1'b0);
        run_block(pt, aes_enc(pt), -1, -1, 0, -1, 50, 1'b0);
        run_block(pt, aes_enc(pt), -1, -1, 0, -1, -1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            run_block(pt, aes_enc(pt),
                      int'($urandom_range(0, 10)),
                      int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 5)),
                      -1, -1, 1'b0);
        end

        @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
